// File: rtl/uart_mem_bridge_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART memory bridge.
package uart_mem_bridge_pkg;

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_M  = 8'h4D;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_CR, P_LF} pstate_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rw;
    logic        valid;
  } bus_t;

  // Uppercase ASCII hex digit for a nibble.
  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Folding bit 5 makes the match case-insensitive; digits already carry it.
  function automatic logic is_hex(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < 16; i++)
      if ((b | 8'h20) == (nib2hex(4'(i)) | 8'h20)) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [3:0] hex2nib(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 16; i++)
      if ((b | 8'h20) == (nib2hex(4'(i)) | 8'h20)) n = 4'(i);
    return n;
  endfunction

  function automatic logic is_write(input logic [7:0] b);
    return (b | 8'h20) == (CH_W | 8'h20);
  endfunction

  function automatic logic is_start(input logic [7:0] b);
    return ((b | 8'h20) == (CH_R | 8'h20)) || is_write(b);
  endfunction

  // Byte idx of the response frame 'M' H H H H CR LF.
  function automatic logic [7:0] resp_byte(input logic [15:0] d, input logic [2:0] idx);
    logic [7:0] b;
    unique case (idx)
      3'd0:    b = CH_M;
      3'd1:    b = nib2hex(d[15:12]);
      3'd2:    b = nib2hex(d[11:8]);
      3'd3:    b = nib2hex(d[7:4]);
      3'd4:    b = nib2hex(d[3:0]);
      3'd5:    b = CH_CR;
      default: b = CH_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_mem_bridge_bank.sv
// One register-file bank on the pipelined bus; owns [BASE_ADDR, BASE_ADDR+DEPTH).
module lut_bank
  import uart_mem_bridge_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic clk,
  input  logic rst,
  input  bus_t bus_i,
  output bus_t bus_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] LO = 17'(BASE_ADDR);
  localparam logic [16:0] HI = 17'(BASE_ADDR + DEPTH);

  logic [15:0]   mem [DEPTH];
  logic          hit;
  logic [AW-1:0] off;
  bus_t          bus_d, bus_q;

  // Address decode and read-data substitution for a hit.
  always_comb begin
    hit   = bus_i.valid && ({1'b0, bus_i.addr} >= LO) && ({1'b0, bus_i.addr} < HI);
    off   = AW'(bus_i.addr - LO[15:0]);
    bus_d = bus_i;
    if (hit && !bus_i.rw) bus_d.rdata = mem[off];
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (hit && bus_i.rw) mem[off] <= bus_i.wdata;
  end

  // Pipeline register towards the next bank.
  always_ff @(posedge clk) begin
    if (rst) bus_q <= '0;
    else     bus_q <= bus_d;
  end

  assign bus_o = bus_q;

endmodule

// File: rtl/uart_mem_bridge.sv
// ASCII request parser -> chained banks -> ASCII response encoder.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned N_BANKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] axiid,
  input  logic       axiiv,
  output logic [7:0] axiod,
  output logic       axiov,
  input  logic       axior
);

  pstate_t     st_q, st_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d, data_q, data_d;
  logic        rw_q, rw_d, restart;
  bus_t        req_q, req_d;
  bus_t        chain [N_BANKS+1];
  logic        rsp_vld_q, rsp_vld_d;
  logic [15:0] rsp_dat_q, rsp_dat_d;
  logic        ov_q, ov_d;
  logic [7:0]  od_q, od_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] hold_q, hold_d;

  // Parser next state; a bad byte restarts, and may itself open a message.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    req_d   = '0;
    restart = 1'b0;
    if (axiiv) begin
      unique case (st_q)
        P_IDLE: restart = 1'b1;
        P_ADDR:
          if (is_hex(axiid)) begin
            addr_d = {addr_q[11:0], hex2nib(axiid)};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) st_d = rw_q ? P_DATA : P_CR;
          end else restart = 1'b1;
        P_DATA:
          if (is_hex(axiid)) begin
            data_d = {data_q[11:0], hex2nib(axiid)};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) st_d = P_CR;
          end else restart = 1'b1;
        P_CR:
          if (axiid == CH_CR) st_d = P_LF;
          else                restart = 1'b1;
        P_LF:
          if (axiid == CH_LF) begin
            st_d        = P_IDLE;
            req_d.addr  = addr_q;
            req_d.wdata = data_q;
            req_d.rw    = rw_q;
            req_d.valid = 1'b1;
          end else restart = 1'b1;
        default: restart = 1'b1;
      endcase
      if (restart) begin
        st_d  = is_start(axiid) ? P_ADDR : P_IDLE;
        cnt_d = '0;
        rw_d  = is_write(axiid);
      end
    end
  end

  assign chain[0] = req_q;

  for (genvar k = 0; k < N_BANKS; k++) begin : g_bank
    lut_bank #(.DEPTH(DEPTH), .BASE_ADDR(k * DEPTH)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .bus_i (chain[k]),
      .bus_o (chain[k+1])
    );
  end

  // Encoder: capture chain reads, then stream the 7-byte frame under axior.
  always_comb begin
    rsp_vld_d = chain[N_BANKS].valid && !chain[N_BANKS].rw;
    rsp_dat_d = chain[N_BANKS].rdata;
    ov_d      = ov_q;
    od_d      = od_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    if (ov_q) begin
      if (axior) begin
        if (idx_q == 3'd6) ov_d = 1'b0;
        else begin
          idx_d = idx_q + 3'd1;
          od_d  = resp_byte(hold_q, idx_q + 3'd1);
        end
      end
    end else if (rsp_vld_q) begin
      ov_d   = 1'b1;
      od_d   = CH_M;
      idx_d  = '0;
      hold_d = rsp_dat_q;
    end
  end

  // State registers for parser, request and encoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= P_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      req_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
      ov_q      <= 1'b0;
      od_q      <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      req_q     <= req_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
      ov_q      <= ov_d;
      od_q      <= od_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
    end
  end

  assign axiov = ov_q;
  assign axiod = od_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Scoreboard bench for uart_mem_bridge: stimulus queues expected bytes, monitor checks.
module tb_uart_mem_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] axiid = 8'h00;
  logic       axiiv = 1'b0;
  logic       axior = 1'b1;
  logic [7:0] axiod;
  logic       axiov;

  uart_mem_bridge #(.DEPTH(8), .N_BANKS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .axiid (axiid),
    .axiiv (axiiv),
    .axiod (axiod),
    .axiov (axiov),
    .axior (axior)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_lf = 0;
  bit          tog = 1'b0;
  logic [7:0]  exp_q [$];
  int unsigned lat_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: constant 1, or toggling every cycle when tog is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      axior = tog ? ~axior : 1'b1;
    end
  end

  // Monitor: latency of first byte, hold under backpressure, byte values.
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        checks++;
        if (!axiov || axiod !== pd) begin
          errors++;
          $display("FAIL hold: axiov=%b axiod=%h, expected axiov=1 axiod=%h", axiov, axiod, pd);
        end
      end
      if (axiov && !pv) begin
        checks++;
        if (lat_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_response: axiov=1 axiod=%h with no request pending", axiod);
        end else begin
          int unsigned lf;
          lf = lat_q.pop_front();
          if (cyc - lf != 5) begin
            errors++;
            $display("FAIL latency: %0d cycles after LF, expected 5", cyc - lf);
          end
        end
      end
      if (axiov && axior) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %h, expected none", axiod);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (axiod !== e) begin
            errors++;
            $display("FAIL byte: got %h, expected %h", axiod, e);
          end
        end
      end
      pv = axiov;
      pr = axior;
      pd = axiod;
    end
  end

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    axiid = b;
    axiiv = 1'b1;
    if (b == 8'h0A) last_lf = cyc + 1;
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic crlf();
    put(8'h0D);
    put(8'h0A);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      axiiv = 1'b0;
    end
  endtask

  task automatic rd(input string cmd, input string resp);
    for (int i = 0; i < resp.len(); i++) exp_q.push_back(resp[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    put_str(cmd);
    crlf();
    lat_q.push_back(last_lf);
  endtask

  task automatic drain(input string name);
    idle(1);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !axiov) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d bytes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    if (axiov !== 1'b0) begin errors++; $display("FAIL reset_axiov: got %b, expected 0", axiov); end
    checks++;
    if (axiod !== 8'h00) begin errors++; $display("FAIL reset_axiod: got %h, expected 00", axiod); end
    rst = 1'b0;

    // Back-to-back writes with no gap between messages.
    put_str("W00010001"); crlf();
    put_str("W00021111"); crlf();
    put_str("W000A2222"); crlf();
    idle(2);
    rd("R0001", "M0001"); drain("r1");

    put_str("W0012BEEF"); crlf(); idle(1);
    rd("r0012", "MBEEF"); drain("r12");
    rd("R0002", "M1111"); drain("r2");
    rd("R000A", "M2222"); drain("ra");

    put_str("W0009abcd"); crlf(); idle(1);
    tog = 1'b1;
    rd("R0009", "MABCD"); drain("r9");
    tog = 1'b0;

    // Malformed messages: nothing may come out.
    put_str("M12345678"); crlf();
    put_str("R00G1"); crlf();
    put_str("R0001"); put(8'h0A);
    idle(20);
    rd("R0001", "M0001"); drain("r1b");

    put_str("W0020FFFF"); crlf(); idle(1);
    rd("R0020", "M0000"); drain("r20");

    // Reset in the middle of a write.
    put_str("W00");
    @(negedge clk);
    axiiv = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (axiov !== 1'b0) begin errors++; $display("FAIL midreset_axiov: got %b, expected 0", axiov); end
    idle(4);
    rd("R0001", "M0001"); drain("r1c");
    idle(10);

    checks++;
    if (exp_q.size() != 0 || lat_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d bytes / %0d responses pending, expected 0", exp_q.size(), lat_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Text-protocol bus bridge: parses ASCII request bytes, runs them through a daisy chain of register-file banks, and serialises read responses back as ASCII bytes.
- Sits between a UART receiver (byte stream in) and a UART transmitter (byte stream out with ready).
- Contains the request parser, N_BANKS LUT-memory banks on a pipelined bus, and the response encoder.

Parameters:
- DEPTH, 8: 16-bit words per bank.
- N_BANKS, 3: number of chained banks; bank k occupies addresses [k*DEPTH, (k+1)*DEPTH).

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- axiid  in  8  received byte
- axiiv  in  1  received byte valid; one byte per cycle when high, no backpressure
- axiod  out  8  response byte
- axiov  out  1  response byte valid
- axior  in  1  downstream ready; byte transfers when axiov && axior

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: axiov=0, axiod=0, parser IDLE, all bus valids 0, encoder idle. Bank contents are not reset (power-up 0).
- Request format: read = 'R' A A A A CR LF; write = 'W' A A A A D D D D CR LF. A/D are hex digits, MSB first, case-insensitive (0-9, A-F, a-f). 'r'/'w' also accepted.
- Parser states: IDLE, ADDR (4 digits), DATA (4 digits, writes only), CR, LF. Only bytes with axiiv=1 are consumed.
- Illegal byte in any state (non-hex digit, missing CR/LF, unknown start char such as 'M'): discard the message, return to IDLE; if that byte is R/W/r/w, it starts a new message. No response is sent for discarded messages.
- On a valid LF: issue one bus request the next cycle: addr[15:0], wdata[15:0], rw (1=write, 0=read), valid=1 for exactly one cycle.
- Bus chain: each bank registers addr/wdata/rw/valid through to the next bank (1-cycle latency per bank). Chain rdata input is 16'h0000.
- Per bank: if valid and BASE <= addr < BASE+DEPTH: write stores wdata at addr-BASE; read drives rdata_o = mem[addr-BASE]. Otherwise rdata_o = rdata_i, registered.
- Out-of-range address: write is ignored; read returns 0x0000 and still produces a response.
- Encoder: on a chain-output valid with rw=0, load the response 'M' H H H H CR LF (7 bytes, uppercase hex, MSB first). Writes produce no response.
- First byte is presented with axiov=1 exactly N_BANKS+2 cycles after the LF beat (5 with defaults).
- axiod is held stable while axiov && !axior; advance on each accepted byte; axiov drops the cycle after LF is accepted.
- A read response arriving while the encoder is busy is dropped; the in-flight response is unaffected. Hosts must wait for LF before the next read.
- rst mid-message or mid-response: parser and encoder abort immediately; no partial request is issued; memory contents are kept.
- Back-to-back writes, one per message, are supported with no gaps between messages.

Decomposition:
- Package uart_mem_bridge_pkg: ASCII constants (R, W, M, CR, LF), hex-to-nibble and nibble-to-hex functions, bus struct {addr, wdata, rdata, rw, valid}.
- One natural sub-module: lut_bank (parameters DEPTH, BASE_ADDR), instantiated N_BANKS times in a generate loop. Parser and encoder stay inline.

Test Plan:
- Send "R0001\r\n" after writing 0x0001 to addr 1 -> bytes "M0001\r\n", first byte 5 cycles after LF.
- Send "W0012BEEF\r\n", then "r0012\r\n" -> "MBEEF\r\n" (bank 2, offset 2); banks 0 and 1 unchanged.
- Send "W0009abcd\r\n", then read 0x0009 with axior toggling 1/0 every cycle -> "MABCD\r\n" with no byte lost or repeated.
- Send "M12345678\r\n", "R00G1\r\n", and "R0001\n" -> no output, no memory change; an immediately following "R0001\r\n" answers normally.
- Send "W0020FFFF\r\n", then "R0020\r\n" -> write ignored, response "M0000\r\n".
- Assert rst after "W00" -> no request issued; the next complete "R0001\r\n" responds correctly.
